// File: rtl/contador_monitor.sv
// contador_monitor: resynchronises and debounces a ripple counter, classifies each accepted step and queues coded events
module contador_monitor #(
  parameter int WIDTH = 5,
  parameter int STABLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] match_value,
  input  logic             match_en,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] count_stable,
  output logic             count_valid,
  output logic             dir_down,
  output logic             wrap_pulse,
  output logic             match_pulse,
  output logic             step_error,
  output logic             evt_valid,
  output logic [1:0]       evt_code,
  output logic [WIDTH-1:0] evt_value,
  output logic             overflow
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
  logic [WIDTH-1:0] s1, s2, d, t_val;
  logic [CW-1:0] stab_cnt, stab_nxt;
  logic [1:0] code, t_code;
  logic accept, down, up, wrap, err, match, push, pop, t_valid;
  // s2 changes on this edge exactly when s1 differs from it, so stab_nxt is the hold count s2 will report
  always_comb begin
    stab_nxt = (s1 != s2) ? CW'(1) : (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + CW'(1);
    accept = (stab_nxt == STAB_MAX) && ((s2 != count_stable) || !count_valid);
    d = s2 - count_stable;
    down = count_valid && (d == '1);
    up = count_valid && (d == WIDTH'(1));
    err = count_valid && !down && !up;
    wrap = (down && (count_stable == '0)) || (up && (count_stable == '1));
    match = match_en && (s2 == match_value);
    code = err ? 2'd3 : wrap ? 2'd2 : match ? 2'd1 : 2'd0;
    push = accept && (code != 2'd0);
    pop = evt_valid && evt_ready;
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      s1 <= '0;
      s2 <= '0;
      stab_cnt <= '0;
      count_stable <= '0;
      count_valid <= 1'b0;
      dir_down <= 1'b1;
      wrap_pulse <= 1'b0;
      match_pulse <= 1'b0;
      step_error <= 1'b0;
      evt_valid <= 1'b0;
      evt_code <= '0;
      evt_value <= '0;
      t_valid <= 1'b0;
      t_code <= '0;
      t_val <= '0;
      overflow <= 1'b0;
    end else begin
      s1 <= count_in;
      s2 <= s1;
      stab_cnt <= stab_nxt;
      wrap_pulse <= accept && wrap;
      match_pulse <= accept && match;
      step_error <= accept && err;
      if (accept) begin
        count_stable <= s2;
        count_valid <= 1'b1;
        if (down) dir_down <= 1'b1;
        else if (up) dir_down <= 1'b0;
      end
      // evt_* is the head slot, t_* the second slot behind it
      if (pop) begin
        if (t_valid) begin
          evt_code <= t_code;
          evt_value <= t_val;
          t_valid <= push;
          if (push) begin
            t_code <= code;
            t_val <= s2;
          end
        end else if (push) begin
          evt_code <= code;
          evt_value <= s2;
        end else evt_valid <= 1'b0;
      end else if (push) begin
        if (!evt_valid) begin
          evt_valid <= 1'b1;
          evt_code <= code;
          evt_value <= s2;
        end else if (!t_valid) begin
          t_valid <= 1'b1;
          t_code <= code;
          t_val <= s2;
        end else overflow <= 1'b1;
      end
    end
  end
endmodule

// File: doc/contador_monitor.md
Name: contador_monitor

Overview:
- Downstream consumer of the 5-bit ripple down-counter output; runs on the system clock.
- Resynchronises the asynchronous ripple value and filters ripple glitches; accepts a value only after it has been stable.
- Classifies each accepted step as down, up, wrap or illegal jump, and detects a programmable match.
- Queues coded events in a 2-entry FIFO behind a valid/ready handshake.

Parameters:
WIDTH, 5, counter width; all count/value ports are WIDTH bits.
STABLE_CYCLES, 2, consecutive equal synchronised samples required before acceptance (>=1).

Ports:
clk  input  1  system clock, rising edge.
clear  input  1  asynchronous active-high reset.
count_in  input  WIDTH  raw ripple-counter output q, asynchronous to clk.
match_value  input  WIDTH  compare target, sampled at acceptance edge.
match_en  input  1  enables match detection.
evt_ready  input  1  consumer accepts head event this cycle.
count_stable  output  WIDTH  last accepted counter value.
count_valid  output  1  at least one value accepted since clear.
dir_down  output  1  direction of last legal step (1 = down).
wrap_pulse  output  1  one-cycle pulse on legal wrap step.
match_pulse  output  1  one-cycle pulse on match.
step_error  output  1  one-cycle pulse on illegal jump.
evt_valid  output  1  FIFO head valid.
evt_code  output  2  head event: 1 match, 2 wrap, 3 step error.
evt_value  output  WIDTH  count_stable value associated with head event.
overflow  output  1  sticky: event dropped because FIFO full.

Behaviour:
- clear (async, any time, including mid-operation): sync regs, stability counter, count_stable and FIFO contents = 0; count_valid 0; dir_down 1; all pulses 0; evt_valid 0; evt_code 0; evt_value 0; overflow 0. In-flight samples are discarded.
- Synchroniser: s1 <= count_in, s2 <= s1 every edge. No logic uses s1 directly.
- Stability: stab_cnt resets to 1 when s2 changes and increments, saturating, while s2 holds.
- Acceptance edge: stab_cnt == STABLE_CYCLES and s2 != count_stable, or first acceptance with count_valid 0.
- Latency: count_in changes before edge E0 and holds; with default STABLE_CYCLES=2, acceptance occurs at E2, so count_stable and the pulses are visible after E2.
- First acceptance after clear:
  - count_valid <= 1.
  - No step, wrap or error classification; dir_down is unchanged.
  - Match is still evaluated.
- Later acceptance: d = (new - old) mod 2^WIDTH.
  - d = 2^WIDTH-1: legal down step; dir_down <= 1; wrap_pulse if old = 0, new = all-ones.
  - d = 1: legal up step; dir_down <= 0; wrap_pulse if old = all-ones, new = 0.
  - Any other d: step_error pulse; dir_down unchanged; no wrap.
- match_pulse: match_en && new == match_value. This is independent of step legality.
- Pulses last exactly one cycle and are 0 on non-acceptance cycles.
- Event generation: at most one event per acceptance, highest priority wins: step error (3) > wrap (2) > match (1). evt_value = new value.
- FIFO: 2 entries, first-in first-out.
  - Pop when evt_valid && evt_ready.
  - evt_code and evt_value hold stable while evt_valid && !evt_ready.
  - Push and pop on the same edge: both occur, including when full (no drop).
  - Push when full without pop: event dropped, overflow <= 1 until clear, FIFO unchanged.
  - Empty FIFO: evt_valid 0; evt_code/evt_value hold last popped values (no reuse required).
- No combinational path from count_in to any output; all outputs are registered.

Test Plan:
- Assert clear mid-stream with FIFO holding 2 events and count_stable = 9 -> all outputs at reset values immediately (dir_down = 1); the next accepted value is treated as first acceptance (no step_error).
- After clear, count_in = 5 held -> count_stable = 5 and count_valid = 1 after 3rd edge, no pulses; then 4 -> dir_down = 1, no pulses, no event.
- Sequence 1, 0, 31 with match_en = 1, match_value = 31 -> on 31: wrap_pulse and match_pulse in the same cycle; one event only: code 2, value 31.
- 1-cycle glitch count_in 8 -> 12 -> 8 while count_stable = 8 -> no acceptance, no pulses, count_stable stays 8.
- Jump 20 -> 17 -> step_error pulse, event code 3, value 17, dir_down unchanged; then 17 -> 18 -> dir_down = 0.
- evt_ready = 0, generate 3 events -> first two held in order, third dropped, overflow = 1. Then evt_ready = 1 while a 4th event arrives with the FIFO full -> pop and push on the same edge, no drop; overflow stays 1.
